// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alarm_pkg
// Description : Shared types and constants for the alarm controller slice.
//               State encoding for the sequencing FSM, the width of the BCD
//               time word and the bit offsets of each BCD digit within it.
// Revision    : 1.0 - initial release
// ============================================================================
package alarm_pkg;

    // Packed BCD time word: {hourMSB, hourLSB, minMSB, minLSB, secMSB, secLSB}
    localparam int TIME_W       = 24;
    localparam int DIGIT_W      = 4;
    localparam int SEC_LSB_OFS  = 0;
    localparam int SEC_MSB_OFS  = 4;
    localparam int MIN_LSB_OFS  = 8;
    localparam int MIN_MSB_OFS  = 12;
    localparam int HOUR_LSB_OFS = 16;
    localparam int HOUR_MSB_OFS = 20;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SET     = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
// Module      : button_repeat
// Description : Rising-edge detector with auto-repeat for a debounced button.
//               An accepted press gives a one-cycle pulse the next cycle; while
//               the button stays held and enabled, another pulse follows every
//               REPEAT_DIV cycles. Repeat only runs after a press that was
//               accepted while enabled, so a button already held when enable
//               rises stays silent until it is released and pressed again.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               btn      - debounced button level
//               en       - enable; low discards edges and clears the repeat
//               pulse    - registered one-cycle increment pulse
// Revision    : 1.0 - initial release
// ============================================================================
module button_repeat #(
    parameter int REPEAT_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    input  logic en,
    output logic pulse
);

    localparam int                CNT_W    = $clog2(REPEAT_DIV) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REPEAT_DIV - 1);

    logic             r_btn_prev;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;
    logic             w_edge;

    assign w_edge = btn & ~r_btn_prev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // Previous value resets high: a button held through reset
            // release must not look like a fresh press.
            r_btn_prev <= 1'b1;
            r_armed    <= 1'b0;
            r_cnt      <= '0;
            pulse      <= 1'b0;
        end else begin
            r_btn_prev <= btn;
            pulse      <= 1'b0;
            if (en && w_edge) begin
                pulse   <= 1'b1;
                r_armed <= 1'b1;
                r_cnt   <= '0;
            end else if (en && btn && r_armed) begin
                if (r_cnt == CNT_LAST) begin
                    pulse <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                // Released or disabled: forget the press entirely.
                r_armed <= 1'b0;
                r_cnt   <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : alarm_controller
// Description : Sequencing FSM for the alarm clock. Generates increment pulses
//               for the alarm-time counter in SET mode, detects the alarm
//               time, rings, and handles snooze and off.
// Ports       : clk          - system clock
//               reset_n      - asynchronous active-low reset
//               tick_1hz     - one-cycle pulse per second
//               alarm_en     - alarm arm switch (level)
//               btn_mode     - toggles SET mode (debounced level)
//               btn_up_hour  - alarm hour increment button
//               btn_up_min   - alarm minute increment button
//               btn_snooze   - snooze button
//               btn_off      - alarm off button
//               cur_time     - current BCD time
//               alm_time     - alarm BCD time
//               uphour       - one-cycle hour increment pulse
//               upmin        - one-cycle minute increment pulse
//               ringing      - buzzer enable
//               set_mode     - high in SET
//               snoozing     - high in SNOOZE
// Revision    : 1.0 - initial release
// ============================================================================
module alarm_controller
    import alarm_pkg::*;
#(
    parameter int REPEAT_DIV  = 25_000_000,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              tick_1hz,
    input  logic              alarm_en,
    input  logic              btn_mode,
    input  logic              btn_up_hour,
    input  logic              btn_up_min,
    input  logic              btn_snooze,
    input  logic              btn_off,
    input  logic [TIME_W-1:0] cur_time,
    input  logic [TIME_W-1:0] alm_time,
    output logic              uphour,
    output logic              upmin,
    output logic              ringing,
    output logic              set_mode,
    output logic              snoozing
);

    localparam int                RING_W    = $clog2(RING_SECS) + 1;
    localparam int                SNZ_W     = $clog2(SNOOZE_SECS) + 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SECS - 1);
    localparam logic [SNZ_W-1:0]  SNZ_LOAD  = SNZ_W'(SNOOZE_SECS);
    localparam logic [SNZ_W-1:0]  SNZ_ONE   = SNZ_W'(1);

    state_t            r_state;
    logic [RING_W-1:0] r_ring_cnt;
    logic [SNZ_W-1:0]  r_snz_cnt;
    logic              r_mode_prev;
    logic              r_snooze_prev;
    logic              r_off_prev;
    logic              r_match_q;

    logic              w_mode_edge;
    logic              w_snooze_edge;
    logic              w_off_edge;
    logic              w_match;
    logic              w_trigger;
    logic              w_hour_en;
    logic              w_min_en;

    assign w_mode_edge   = btn_mode   & ~r_mode_prev;
    assign w_snooze_edge = btn_snooze & ~r_snooze_prev;
    assign w_off_edge    = btn_off    & ~r_off_prev;

    // Rising edge of the match only, so one matching second rings once.
    assign w_match   = (cur_time == alm_time);
    assign w_trigger = w_match & ~r_match_q & alarm_en;

    // A mode edge in SET leaves SET on the next cycle, so it also blocks any
    // pulse that would otherwise land outside SET. Hour outranks minute: the
    // minute generator is held disabled for as long as hour is down.
    assign w_hour_en = (r_state == SET) & ~w_mode_edge;
    assign w_min_en  = w_hour_en & ~btn_up_hour;

    button_repeat #(
        .REPEAT_DIV (REPEAT_DIV)
    ) u_hour_repeat (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_up_hour),
        .en      (w_hour_en),
        .pulse   (uphour)
    );

    button_repeat #(
        .REPEAT_DIV (REPEAT_DIV)
    ) u_min_repeat (
        .clk     (clk),
        .reset_n (reset_n),
        .btn     (btn_up_min),
        .en      (w_min_en),
        .pulse   (upmin)
    );

    // Status outputs are registered alongside the state, so each transition
    // updates them together with r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_ring_cnt    <= '0;
            r_snz_cnt     <= '0;
            r_mode_prev   <= 1'b1;
            r_snooze_prev <= 1'b1;
            r_off_prev    <= 1'b1;
            r_match_q     <= 1'b1;
            ringing       <= 1'b0;
            set_mode      <= 1'b0;
            snoozing      <= 1'b0;
        end else begin
            r_mode_prev   <= btn_mode;
            r_snooze_prev <= btn_snooze;
            r_off_prev    <= btn_off;
            r_match_q     <= w_match;

            case (r_state)
                IDLE: begin
                    if (w_mode_edge) begin
                        r_state  <= SET;
                        set_mode <= 1'b1;
                    end else if (w_trigger) begin
                        r_state    <= RINGING;
                        r_ring_cnt <= '0;
                        ringing    <= 1'b1;
                    end
                end

                SET: begin
                    if (w_mode_edge) begin
                        r_state  <= IDLE;
                        set_mode <= 1'b0;
                    end
                end

                RINGING: begin
                    if (!alarm_en || w_off_edge) begin
                        r_state <= IDLE;
                        ringing <= 1'b0;
                    end else if (w_snooze_edge) begin
                        r_state   <= SNOOZE;
                        r_snz_cnt <= SNZ_LOAD;
                        ringing   <= 1'b0;
                        snoozing  <= 1'b1;
                    end else if (tick_1hz) begin
                        if (r_ring_cnt == RING_LAST) begin
                            r_state <= IDLE;
                            ringing <= 1'b0;
                        end else begin
                            r_ring_cnt <= r_ring_cnt + 1'b1;
                        end
                    end
                end

                SNOOZE: begin
                    if (!alarm_en || w_off_edge) begin
                        r_state  <= IDLE;
                        snoozing <= 1'b0;
                    end else if (tick_1hz) begin
                        if (r_snz_cnt == SNZ_ONE) begin
                            r_state    <= RINGING;
                            r_ring_cnt <= '0;
                            ringing    <= 1'b1;
                            snoozing   <= 1'b0;
                        end else begin
                            r_snz_cnt <= r_snz_cnt - 1'b1;
                        end
                    end
                end

                default: begin
                    r_state  <= IDLE;
                    ringing  <= 1'b0;
                    set_mode <= 1'b0;
                    snoozing <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alarm_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_alarm_controller
// Description : Self-checking bench for alarm_controller. Directed scenarios
//               followed by a randomized run, all compared cycle by cycle
//               against a behavioural model of the alarm rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alarm_controller;

    localparam int REPEAT_DIV  = 4;
    localparam int RING_SECS   = 3;
    localparam int SNOOZE_SECS = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SET   = 1;
    localparam int M_RING  = 2;
    localparam int M_SNZ   = 3;

    logic        clk         = 1'b0;
    logic        reset_n     = 1'b0;
    logic        tick_1hz    = 1'b0;
    logic        alarm_en    = 1'b0;
    logic        btn_mode    = 1'b0;
    logic        btn_up_hour = 1'b0;
    logic        btn_up_min  = 1'b0;
    logic        btn_snooze  = 1'b0;
    logic        btn_off     = 1'b0;
    logic [23:0] cur_time    = 24'h000000;
    logic [23:0] alm_time    = 24'h123000;
    logic        uphour;
    logic        upmin;
    logic        ringing;
    logic        set_mode;
    logic        snoozing;

    alarm_controller #(
        .REPEAT_DIV  (REPEAT_DIV),
        .RING_SECS   (RING_SECS),
        .SNOOZE_SECS (SNOOZE_SECS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick_1hz    (tick_1hz),
        .alarm_en    (alarm_en),
        .btn_mode    (btn_mode),
        .btn_up_hour (btn_up_hour),
        .btn_up_min  (btn_up_min),
        .btn_snooze  (btn_snooze),
        .btn_off     (btn_off),
        .cur_time    (cur_time),
        .alm_time    (alm_time),
        .uphour      (uphour),
        .upmin       (upmin),
        .ringing     (ringing),
        .set_mode    (set_mode),
        .snoozing    (snoozing)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- behavioural model ----------------
    int   m_mode;          // what the clock is doing
    int   m_secs_rung;     // whole seconds rung so far
    int   m_secs_left;     // seconds of snooze left
    int   h_age, n_age;    // cycles since last pulse while held
    logic h_armed, n_armed;
    logic p_mode, p_snz, p_off, p_hour, p_min, p_match;
    logic e_uphour, e_upmin;

    task automatic model_reset();
        m_mode = M_IDLE; m_secs_rung = 0; m_secs_left = 0;
        h_age = 0; n_age = 0; h_armed = 1'b0; n_armed = 1'b0;
        p_mode = 1'b1; p_snz = 1'b1; p_off = 1'b1;
        p_hour = 1'b1; p_min = 1'b1; p_match = 1'b1;
        e_uphour = 1'b0; e_upmin = 1'b0;
    endtask

    // Advance the model by one clock using the inputs as they are now.
    task automatic model_update();
        logic pressed_mode, pressed_snz, pressed_off, pressed_hour, pressed_min;
        logic trig, setting, min_ok;
        pressed_mode = btn_mode    && !p_mode;
        pressed_snz  = btn_snooze  && !p_snz;
        pressed_off  = btn_off     && !p_off;
        pressed_hour = btn_up_hour && !p_hour;
        pressed_min  = btn_up_min  && !p_min;
        trig    = (cur_time == alm_time) && !p_match && alarm_en;
        setting = (m_mode == M_SET) && !pressed_mode;
        min_ok  = setting && !btn_up_hour;

        e_uphour = 1'b0;
        e_upmin  = 1'b0;
        if (setting && pressed_hour) begin
            e_uphour = 1'b1; h_age = 0; h_armed = 1'b1;
        end else if (setting && btn_up_hour && h_armed) begin
            h_age++;
            if (h_age == REPEAT_DIV) begin e_uphour = 1'b1; h_age = 0; end
        end else begin
            h_armed = 1'b0; h_age = 0;
        end
        if (min_ok && pressed_min) begin
            e_upmin = 1'b1; n_age = 0; n_armed = 1'b1;
        end else if (min_ok && btn_up_min && n_armed) begin
            n_age++;
            if (n_age == REPEAT_DIV) begin e_upmin = 1'b1; n_age = 0; end
        end else begin
            n_armed = 1'b0; n_age = 0;
        end

        if (m_mode == M_IDLE) begin
            if (pressed_mode)  m_mode = M_SET;
            else if (trig)     begin m_mode = M_RING; m_secs_rung = 0; end
        end else if (m_mode == M_SET) begin
            if (pressed_mode)  m_mode = M_IDLE;
        end else if (m_mode == M_RING) begin
            if (!alarm_en || pressed_off) m_mode = M_IDLE;
            else if (pressed_snz) begin m_mode = M_SNZ; m_secs_left = SNOOZE_SECS; end
            else if (tick_1hz) begin
                m_secs_rung++;
                if (m_secs_rung >= RING_SECS) m_mode = M_IDLE;
            end
        end else begin
            if (!alarm_en || pressed_off) m_mode = M_IDLE;
            else if (tick_1hz) begin
                m_secs_left--;
                if (m_secs_left == 0) begin m_mode = M_RING; m_secs_rung = 0; end
            end
        end

        p_mode = btn_mode; p_snz = btn_snooze; p_off = btn_off;
        p_hour = btn_up_hour; p_min = btn_up_min;
        p_match = (cur_time == alm_time);
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_vs_model();
        check("uphour",   {31'd0, uphour},   {31'd0, e_uphour});
        check("upmin",    {31'd0, upmin},    {31'd0, e_upmin});
        check("ringing",  {31'd0, ringing},  {31'd0, (m_mode == M_RING)});
        check("set_mode", {31'd0, set_mode}, {31'd0, (m_mode == M_SET)});
        check("snoozing", {31'd0, snoozing}, {31'd0, (m_mode == M_SNZ)});
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            model_update();
            @(posedge clk);
            #1;
            check_all_vs_model();
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_outs"}, {27'd0, uphour, upmin, ringing, set_mode, snoozing}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        check_idle_outputs("reset");
    endtask

    logic [9:0] pat_min, pat_hour;
    int         cnt_a, cnt_b;

    initial begin
        model_reset();
        do_reset();
        step(1);

        // 1: set mode, minute held 10 cycles, leave set mode
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        check("t1_set_mode", {31'd0, set_mode}, 32'd1);
        btn_up_min = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            pat_min[i]  = upmin;
            pat_hour[i] = uphour;
        end
        btn_up_min = 1'b0;
        check("t1_upmin_pattern",  {22'd0, pat_min},  32'h111);
        check("t1_uphour_pattern", {22'd0, pat_hour}, 32'h0);
        step(1);
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        check("t1_exit_set", {31'd0, set_mode}, 32'd0);
        step(2);

        // 2: hour priority, minute edge during hour hold discarded
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        cnt_a = 0; cnt_b = 0;
        btn_up_hour = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) btn_up_min = 1'b1;
            step(1);
            cnt_a += int'(uphour);
            cnt_b += int'(upmin);
        end
        check("t2_hour_pulses", cnt_a, 2);
        check("t2_min_while_hour", cnt_b, 0);
        btn_up_hour = 1'b0;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            cnt_a += int'(uphour);
            cnt_b += int'(upmin);
        end
        check("t2_min_after_release", cnt_b, 0);
        check("t2_hour_after_release", cnt_a, 0);
        btn_up_min = 1'b0; step(1);
        btn_up_min = 1'b1; step(1);
        check("t2_fresh_min", {31'd0, upmin}, 32'd1);
        btn_up_min = 1'b0;
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        step(1);

        // 3: match rings next cycle, times out on third tick
        alarm_en = 1'b1;
        cur_time = 24'h122959; step(1);
        cur_time = 24'h123000; step(1);
        check("t3_ring_start", {31'd0, ringing}, 32'd1);
        cur_time = 24'h123001; step(1);
        for (int k = 0; k < 2; k++) begin
            tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(1);
        end
        check("t3_ring_after_2", {31'd0, ringing}, 32'd1);
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        check("t3_ring_timeout", {31'd0, ringing}, 32'd0);
        step(1);

        // 4: snooze, re-ring after two ticks, off
        cur_time = 24'h123000; step(1); cur_time = 24'h123001;
        btn_snooze = 1'b1; step(1); btn_snooze = 1'b0;
        check("t4_snoozing", {30'd0, snoozing, ringing}, 32'h2);
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(1);
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        check("t4_reringing", {30'd0, snoozing, ringing}, 32'h1);
        btn_off = 1'b1; step(1); btn_off = 1'b0;
        check_idle_outputs("t4_off");
        step(1);

        // 5: off beats snooze; alarm_en low cancels snooze
        cur_time = 24'h123000; step(1); cur_time = 24'h123001;
        btn_off = 1'b1; btn_snooze = 1'b1; step(1);
        btn_off = 1'b0; btn_snooze = 1'b0;
        check("t5_off_wins", {30'd0, snoozing, ringing}, 32'h0);
        step(1);
        cur_time = 24'h123000; step(1); cur_time = 24'h123001;
        btn_snooze = 1'b1; step(1); btn_snooze = 1'b0;
        check("t5_snoozing", {31'd0, snoozing}, 32'd1);
        alarm_en = 1'b0; step(1);
        check("t5_disarm", {31'd0, snoozing}, 32'd0);
        alarm_en = 1'b1; step(1);

        // 6: match and hour held across reset release, then async reset
        cur_time = 24'h123000; btn_up_hour = 1'b1;
        do_reset();
        step(3);
        check("t6_no_ring", {31'd0, ringing}, 32'd0);
        btn_mode = 1'b1; step(1); btn_mode = 1'b0;
        cnt_a = 0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            cnt_a += int'(uphour);
        end
        check("t6_no_uphour", cnt_a, 0);
        btn_mode = 1'b1; step(1); btn_mode = 1'b0; btn_up_hour = 1'b0;
        step(1);
        cur_time = 24'h123001; step(1);
        cur_time = 24'h123000; step(1);
        check("t6_ring_before_reset", {31'd0, ringing}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t6_async_clear", {31'd0, ringing}, 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        cur_time = 24'h000000;
        step(2);

        // Randomized run against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 19) == 0) btn_mode    = ~btn_mode;
            if ($urandom_range(0, 4)  == 0) btn_up_hour = ~btn_up_hour;
            if ($urandom_range(0, 4)  == 0) btn_up_min  = ~btn_up_min;
            if ($urandom_range(0, 11) == 0) btn_snooze  = ~btn_snooze;
            if ($urandom_range(0, 24) == 0) btn_off     = ~btn_off;
            alarm_en = ($urandom_range(0, 39) != 0);
            tick_1hz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) begin
                cur_time = alm_time;
            end else begin
                cur_time = 24'($urandom);
                if (cur_time == alm_time) cur_time = cur_time ^ 24'h1;
            end
            step(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Sequencing FSM for the alarm-time BCD counter and the alarm output.
- Converts debounced buttons into single-cycle `uphour`/`upmin` increment pulses, with auto-repeat while held, only in set mode.
- Compares current time against alarm time, rings, and handles snooze and off.
- Sits between the button debouncers/timekeeper and the alarm counter plus buzzer/LED logic.

Parameters:
- REPEAT_DIV, 25_000_000: clk cycles between auto-repeat pulses while an up button is held.
- RING_SECS, 60: seconds ringing continues before self-cancel.
- SNOOZE_SECS, 300: seconds of silence after snooze before re-ringing.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- tick_1hz  in  1  one-cycle pulse per second from the timekeeper
- alarm_en  in  1  alarm arm switch (level)
- btn_mode  in  1  debounced level; toggles set mode
- btn_up_hour  in  1  debounced level
- btn_up_min  in  1  debounced level
- btn_snooze  in  1  debounced level
- btn_off  in  1  debounced level
- cur_time  in  24  BCD {hourMSB,hourLSB,minMSB,minLSB,secMSB,secLSB}
- alm_time  in  24  BCD, same order, from the alarm counter
- uphour  out  1  one-cycle increment pulse to the alarm hour digits
- upmin  out  1  one-cycle increment pulse to the alarm minute digits
- ringing  out  1  buzzer enable
- set_mode  out  1  high in SET
- snoozing  out  1  high in SNOOZE

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values:
  - state = IDLE; all outputs 0; counters 0.
  - Button previous-value registers reset to 1, so a button held through reset release produces no edge.
  - match_q resets to 1, so a time match present at reset release does not ring.
- Edge detection:
  - edge = btn & ~btn_prev.
  - Registered outputs appear in cycle N+1, where N is the first cycle the button is seen high.
- Match:
  - match = (cur_time == alm_time), all 24 bits, registered each cycle into match_q.
  - trigger = match & ~match_q & alarm_en, i.e. a rising edge only. One trigger per matching second.
- States: IDLE, SET, RINGING, SNOOZE.
- IDLE:
  - btn_mode edge -> SET.
  - Else trigger -> RINGING, ring_cnt = 0.
  - Mode edge and trigger in the same cycle: SET wins and the trigger is dropped.
- SET:
  - btn_up_hour edge -> uphour pulse.
  - While still held, a further pulse every REPEAT_DIV cycles. The first repeat comes REPEAT_DIV cycles after the initial pulse.
  - upmin behaves identically for btn_up_min.
  - Both held: hour has priority. Minute pulses and the minute repeat counter are suppressed until hour is released; a minute edge occurring while hour is held is discarded.
  - Releasing a button clears its repeat counter.
  - btn_mode edge -> IDLE, and repeat counters clear.
  - Triggers are ignored in SET.
  - uphour/upmin are never asserted outside SET.
- RINGING:
  - ringing = 1.
  - ring_cnt increments on tick_1hz; reaching RING_SECS -> IDLE.
  - Exit priority, highest first: ~alarm_en -> IDLE; btn_off edge -> IDLE; btn_snooze edge -> SNOOZE with snz_cnt = SNOOZE_SECS; timeout -> IDLE.
  - btn_mode is ignored.
- SNOOZE:
  - snoozing = 1.
  - snz_cnt decrements on tick_1hz; when it decrements to 0 -> RINGING with ring_cnt = 0.
  - ~alarm_en or btn_off edge -> IDLE, with priority over expiry.
  - btn_mode and btn_snooze are ignored.
- Reset asserted mid-operation: immediate return to reset values, including any pulse in flight.
- Counter widths: $clog2 of the respective parameter + 1. No wrap occurs, because counters are bounded by the FSM.

Decomposition:
- Package alarm_pkg holds:
  - the state enum {IDLE, SET, RINGING, SNOOZE};
  - the BCD time width constant (24) and digit field offsets.
- Sub-module button_repeat (params REPEAT_DIV): edge detect plus auto-repeat pulse generator with an enable input.
  - Instantiated twice, for hour and minute.
  - The remaining buttons use plain edge registers in the top level.

Test Plan:
All tests use REPEAT_DIV=4, RING_SECS=3, SNOOZE_SECS=2.
1. Mode edge, then btn_up_min held 10 cycles -> upmin pulses at cycles +1, +5, +9 relative to press; uphour stays 0; a second mode edge returns to IDLE with set_mode=0.
2. In SET, hour held, then min pressed during hold, hour released -> only uphour pulses while hour is held; no upmin until a fresh min edge.
3. alarm_en=1, cur_time steps to equal alm_time 12:30:00 -> ringing asserted one cycle after match; with no buttons pressed, ringing drops after the 3rd tick_1hz.
4. Ringing, snooze edge -> snoozing=1, ringing=0; after 2 ticks -> ringing=1 again; off edge -> IDLE, all outputs 0.
5. Ringing with off and snooze edges in the same cycle -> IDLE, not SNOOZE; alarm_en dropped during SNOOZE -> IDLE.
6. Match present and btn_up_hour held across reset_n release -> no ringing and no uphour pulse after release; asserting reset_n low mid-RINGING clears ringing asynchronously.
